write_scheduler: RTL

Round-robin scheduler that shares the single write port of the downstream byte FIFO between NUM_WRITERS requesting Writer modules.
- Each writer presents a data byte and holds i_req; the scheduler picks one writer per grant cycle and drives o_we/o_data.
- It releases the chosen writer through its o_busy line.
- It stalls all writers while the FIFO reports full.

---
 rtl/write_scheduler_if.sv | 22 ++
 rtl/write_scheduler.sv | 124 ++++++++++++
 2 files changed

// File: rtl/write_scheduler_if.sv
// rtl/write_scheduler_if.sv - writer request bus and FIFO write port of the write scheduler
interface write_scheduler_if #(
    parameter int NUM_WRITERS = 2,
    parameter int DATA_W      = 8
);
    logic [NUM_WRITERS*DATA_W-1:0] i_data;
    logic [NUM_WRITERS-1:0]        i_req;
    logic                          i_fifo_full;
    logic [NUM_WRITERS-1:0]        o_busy;
    logic                          o_we;
    logic [DATA_W-1:0]             o_data;

    modport master (
        output i_data, i_req, i_fifo_full,
        input  o_busy, o_we, o_data
    );

    modport slave (
        input  i_data, i_req, i_fifo_full,
        output o_busy, o_we, o_data
    );
endinterface

// File: rtl/write_scheduler.sv
// rtl/write_scheduler.sv - round-robin arbiter sharing one FIFO write port between writers
// Optional regrant bursts of up to MAX_BURST when WRITE_SCHEDULER_BURST_EN is defined.
module write_scheduler #(
    parameter int NUM_WRITERS = 2,
    parameter int DATA_W      = 8
`ifdef WRITE_SCHEDULER_BURST_EN
    ,
    parameter int MAX_BURST   = 4
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    write_scheduler_if.slave  bus
);
    localparam int PTR_W = (NUM_WRITERS > 1) ? $clog2(NUM_WRITERS) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       rr_q, rr_d;
    logic                   we_q, we_d;
    logic [NUM_WRITERS-1:0] busy_q, busy_d;
    logic [DATA_W-1:0]      data_q, data_d;

    logic [PTR_W-1:0]       rr_win;
    logic [PTR_W-1:0]       win;
    logic                   found;
    int unsigned            idx;

`ifdef WRITE_SCHEDULER_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    logic [PTR_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             regrant;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            we_q    <= 1'b0;
            busy_q  <= '1;
            data_q  <= '0;
`ifdef WRITE_SCHEDULER_BURST_EN
            last_q  <= '0;
            burst_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
`ifdef WRITE_SCHEDULER_BURST_EN
            last_q  <= last_d;
            burst_q <= burst_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        we_d    = 1'b0;
        busy_d  = '1;
        data_d  = data_q;
        rr_win  = '0;
        win     = '0;
        found   = 1'b0;
        idx     = 0;
`ifdef WRITE_SCHEDULER_BURST_EN
        last_d  = last_q;
        burst_d = burst_q;
        regrant = 1'b0;
`endif

        // Scan downwards so the requester closest to rr_q is the last to be latched.
        for (int i = NUM_WRITERS - 1; i >= 0; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_WRITERS) begin
                idx = idx - NUM_WRITERS;
            end
            if (bus.i_req[idx]) begin
                rr_win = PTR_W'(idx);
                found  = 1'b1;
            end
        end
        win = rr_win;

`ifdef WRITE_SCHEDULER_BURST_EN
        // rr_q already points past the previous winner, so a regrant leaves it untouched.
        regrant = (burst_q != '0) && (burst_q < CNT_W'(MAX_BURST)) && bus.i_req[last_q];
        if (regrant) begin
            win = last_q;
        end
`endif

        case (state_q)
            IDLE: begin
                if (found && !bus.i_fifo_full) begin
                    state_d     = GRANT;
                    we_d        = 1'b1;
                    busy_d[win] = 1'b0;
                    data_d      = bus.i_data[int'(win)*DATA_W +: DATA_W];
                    rr_d        = (int'(win) == NUM_WRITERS - 1) ? '0 : win + PTR_W'(1);
`ifdef WRITE_SCHEDULER_BURST_EN
                    last_d      = win;
                    burst_d     = regrant ? burst_q + CNT_W'(1) : CNT_W'(1);
`endif
                end
            end
            GRANT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_busy = busy_q;
    assign bus.o_we   = we_q;
    assign bus.o_data = data_q;
endmodule
